// File: rtl/speicher_arbiter.sv
// Arbitrates CPU instruction fetches and data loads/stores onto a single memory port,
// with round-robin on ties, registered outputs and an optional access timeout.
module speicher_arbiter #(
  parameter int unsigned ZEITLIMIT = 255
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] InstruktionAdresse,
  input  logic        LeseInstruktion,
  input  logic [31:0] DatenAdresse,
  input  logic [31:0] DatenRaus,
  input  logic        LeseDaten,
  input  logic        SchreibeDaten,
  output logic [31:0] Instruktion,
  output logic        InstruktionGeladen,
  output logic [31:0] DatenRein,
  output logic        DatenGeladen,
  output logic        DatenGespeichert,
  output logic [31:0] SpeicherAdresse,
  output logic [31:0] SpeicherDatenRaus,
  output logic        SpeicherLesen,
  output logic        SpeicherSchreiben,
  input  logic        SpeicherBereit,
  input  logic [31:0] SpeicherDatenRein,
  output logic        Fehler
);

  typedef enum logic [1:0] {LEERLAUF, ZUGRIFF, FERTIG} zustandTyp;
  typedef enum logic {PORT_INSTRUKTION, PORT_DATEN} portTyp;

  localparam bit          ZEITLIMIT_AKTIV = (ZEITLIMIT != 0);
  localparam logic [31:0] ZAEHLER_ENDE    = 32'(ZEITLIMIT - 1);

  zustandTyp   zustand, zustandNext;
  portTyp      letzterGewinner, gewinnerNext;
  portTyp      aktivPort, portNext;
  logic        aktivSchreiben, schreibenNext;
  logic [31:0] zaehler, zaehlerNext;

  logic [31:0] instruktionNext, datenReinNext, adresseNext, datenRausNext;
  logic        lesenNext, schreibStrobeNext, fehlerNext;
  logic        instrGeladenNext, datenGeladenNext, gespeichertNext;

  logic        datenAnfrage, waehleDaten, abschluss;
  logic [31:0] leseWert;

  // A simultaneous load and store counts as a store; on a tie the port that lost last time wins.
  assign datenAnfrage = LeseDaten | SchreibeDaten;
  assign waehleDaten  = datenAnfrage &&
                        (!LeseInstruktion || (letzterGewinner == PORT_INSTRUKTION));

  // Next-state and next-output logic; every output is a register fed from here.
  always_comb begin
    zustandNext       = zustand;
    gewinnerNext      = letzterGewinner;
    portNext          = aktivPort;
    schreibenNext     = aktivSchreiben;
    zaehlerNext       = zaehler;
    instruktionNext   = Instruktion;
    datenReinNext     = DatenRein;
    adresseNext       = SpeicherAdresse;
    datenRausNext     = SpeicherDatenRaus;
    lesenNext         = SpeicherLesen;
    schreibStrobeNext = SpeicherSchreiben;
    fehlerNext        = Fehler;
    instrGeladenNext  = 1'b0;
    datenGeladenNext  = 1'b0;
    gespeichertNext   = 1'b0;
    abschluss         = 1'b0;
    leseWert          = 32'h0;

    case (zustand)
      LEERLAUF: begin
        lesenNext         = 1'b0;
        schreibStrobeNext = 1'b0;
        if (LeseInstruktion || datenAnfrage) begin
          zustandNext = ZUGRIFF;
          zaehlerNext = 32'h0;
          if (waehleDaten) begin
            portNext          = PORT_DATEN;
            gewinnerNext      = PORT_DATEN;
            schreibenNext     = SchreibeDaten;
            adresseNext       = DatenAdresse;
            datenRausNext     = DatenRaus;
            lesenNext         = !SchreibeDaten;
            schreibStrobeNext = SchreibeDaten;
          end else begin
            portNext      = PORT_INSTRUKTION;
            gewinnerNext  = PORT_INSTRUKTION;
            schreibenNext = 1'b0;
            adresseNext   = InstruktionAdresse;
            lesenNext     = 1'b1;
          end
        end
      end

      ZUGRIFF: begin
        // A ready memory always beats a timeout expiring in the same cycle.
        abschluss = SpeicherBereit || (ZEITLIMIT_AKTIV && (zaehler == ZAEHLER_ENDE));
        if (abschluss) begin
          zustandNext       = FERTIG;
          lesenNext         = 1'b0;
          schreibStrobeNext = 1'b0;
          leseWert          = SpeicherBereit ? SpeicherDatenRein : 32'h0;
          if (!SpeicherBereit) begin
            fehlerNext = 1'b1;
          end
          if (aktivSchreiben) begin
            gespeichertNext = 1'b1;
          end else if (aktivPort == PORT_DATEN) begin
            datenReinNext    = leseWert;
            datenGeladenNext = 1'b1;
          end else begin
            instruktionNext  = leseWert;
            instrGeladenNext = 1'b1;
          end
        end else begin
          zaehlerNext = zaehler + 32'd1;
        end
      end

      FERTIG: zustandNext = LEERLAUF;

      default: zustandNext = LEERLAUF;
    endcase
  end

  // State and output registers; reset aborts any access without a done pulse.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      zustand            <= LEERLAUF;
      letzterGewinner    <= PORT_DATEN;
      aktivPort          <= PORT_INSTRUKTION;
      aktivSchreiben     <= 1'b0;
      zaehler            <= 32'h0;
      Instruktion        <= 32'h0;
      DatenRein          <= 32'h0;
      SpeicherAdresse    <= 32'h0;
      SpeicherDatenRaus  <= 32'h0;
      SpeicherLesen      <= 1'b0;
      SpeicherSchreiben  <= 1'b0;
      Fehler             <= 1'b0;
      InstruktionGeladen <= 1'b0;
      DatenGeladen       <= 1'b0;
      DatenGespeichert   <= 1'b0;
    end else begin
      zustand            <= zustandNext;
      letzterGewinner    <= gewinnerNext;
      aktivPort          <= portNext;
      aktivSchreiben     <= schreibenNext;
      zaehler            <= zaehlerNext;
      Instruktion        <= instruktionNext;
      DatenRein          <= datenReinNext;
      SpeicherAdresse    <= adresseNext;
      SpeicherDatenRaus  <= datenRausNext;
      SpeicherLesen      <= lesenNext;
      SpeicherSchreiben  <= schreibStrobeNext;
      Fehler             <= fehlerNext;
      InstruktionGeladen <= instrGeladenNext;
      DatenGeladen       <= datenGeladenNext;
      DatenGespeichert   <= gespeichertNext;
    end
  end

endmodule

// File: tb/tb_speicher_arbiter.sv
// Bench for speicher_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_speicher_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        Clock, Reset;
  logic [31:0] InstruktionAdresse, DatenAdresse, DatenRaus, SpeicherDatenRein;
  logic        LeseInstruktion, LeseDaten, SchreibeDaten, SpeicherBereit;
  logic [31:0] Instruktion, DatenRein, SpeicherAdresse, SpeicherDatenRaus;
  logic        InstruktionGeladen, DatenGeladen, DatenGespeichert;
  logic        SpeicherLesen, SpeicherSchreiben, Fehler;

  int nChecks = 0;
  int nPass   = 0;

  speicher_arbiter #(.ZEITLIMIT(LIMIT)) dut (
    .Clock(Clock), .Reset(Reset),
    .InstruktionAdresse(InstruktionAdresse), .LeseInstruktion(LeseInstruktion),
    .DatenAdresse(DatenAdresse), .DatenRaus(DatenRaus),
    .LeseDaten(LeseDaten), .SchreibeDaten(SchreibeDaten),
    .Instruktion(Instruktion), .InstruktionGeladen(InstruktionGeladen),
    .DatenRein(DatenRein), .DatenGeladen(DatenGeladen), .DatenGespeichert(DatenGespeichert),
    .SpeicherAdresse(SpeicherAdresse), .SpeicherDatenRaus(SpeicherDatenRaus),
    .SpeicherLesen(SpeicherLesen), .SpeicherSchreiben(SpeicherSchreiben),
    .SpeicherBereit(SpeicherBereit), .SpeicherDatenRein(SpeicherDatenRein),
    .Fehler(Fehler)
  );

  always #5 Clock = ~Clock;

  // Transaction model: one pending access at a time, then one done cycle.
  bit          mBusy = 0, mFertig = 0, mPortDaten = 0, mWrite = 0, mLastDaten = 1;
  int          mWaited = 0;
  logic [31:0] mAddr = 0, mData = 0, mInstr = 0, mDatenRein = 0;
  bit          mFehler = 0;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mBusy = 0; mFertig = 0; mPortDaten = 0; mWrite = 0; mLastDaten = 1;
      mWaited = 0; mAddr = 0; mData = 0; mInstr = 0; mDatenRein = 0; mFehler = 0;
    end else if (mFertig) begin
      mFertig = 0;
    end else if (!mBusy) begin
      if (LeseInstruktion || LeseDaten || SchreibeDaten) begin
        mPortDaten = (LeseDaten || SchreibeDaten) && (!LeseInstruktion || !mLastDaten);
        mLastDaten = mPortDaten;
        mWrite     = mPortDaten && SchreibeDaten;
        mAddr      = mPortDaten ? DatenAdresse : InstruktionAdresse;
        mData      = DatenRaus;
        mWaited    = 0;
        mBusy      = 1;
      end
    end else begin
      if (SpeicherBereit || mWaited + 1 == int'(LIMIT)) begin
        if (!mWrite && mPortDaten)  mDatenRein = SpeicherBereit ? SpeicherDatenRein : 32'h0;
        if (!mWrite && !mPortDaten) mInstr     = SpeicherBereit ? SpeicherDatenRein : 32'h0;
        if (!SpeicherBereit) mFehler = 1;
        mBusy   = 0;
        mFertig = 1;
      end else begin
        mWaited++;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] ist, input logic [31:0] soll);
    nChecks++;
    if (ist === soll) nPass++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, ist, soll, $time);
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge Clock);
      checkOutput("m_lesen",       32'(SpeicherLesen),      32'(mBusy && !mWrite));
      checkOutput("m_schreiben",   32'(SpeicherSchreiben),  32'(mBusy && mWrite));
      checkOutput("m_instrGel",    32'(InstruktionGeladen), 32'(mFertig && !mPortDaten));
      checkOutput("m_datenGel",    32'(DatenGeladen),       32'(mFertig && mPortDaten && !mWrite));
      checkOutput("m_gespeichert", 32'(DatenGespeichert),   32'(mFertig && mWrite));
      checkOutput("m_fehler",      32'(Fehler),             32'(mFehler));
      checkOutput("m_instruktion", Instruktion,             mInstr);
      checkOutput("m_datenRein",   DatenRein,               mDatenRein);
      if (mBusy) begin
        checkOutput("m_adresse", SpeicherAdresse, mAddr);
        if (mWrite) checkOutput("m_datenRaus", SpeicherDatenRaus, mData);
      end
    end
  end

  task automatic applyStimulus(input logic li, input logic [31:0] ia, input logic ld,
                               input logic sd, input logic [31:0] da, input logic [31:0] dr,
                               input logic bereit, input logic [31:0] srein);
    @(negedge Clock);
    LeseInstruktion    = li;
    InstruktionAdresse = ia;
    LeseDaten          = ld;
    SchreibeDaten      = sd;
    DatenAdresse       = da;
    DatenRaus          = dr;
    SpeicherBereit     = bereit;
    SpeicherDatenRein  = srein;
  endtask

  task automatic pulseReset();
    @(posedge Clock); #2 Reset = 1'b1;
    @(posedge Clock); #2 Reset = 1'b0;
  endtask

  initial begin
    Clock = 0; Reset = 1;
    LeseInstruktion = 0; LeseDaten = 0; SchreibeDaten = 0; SpeicherBereit = 0;
    InstruktionAdresse = 0; DatenAdresse = 0; DatenRaus = 0; SpeicherDatenRein = 0;
    repeat (2) @(negedge Clock);
    checkOutput("rst_lesen",   32'(SpeicherLesen), 32'h0);
    checkOutput("rst_adresse", SpeicherAdresse,    32'h0);
    checkOutput("rst_fehler",  32'(Fehler),        32'h0);
    Reset = 0;

    // Fetch with memory ready two cycles after the strobe.
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 0);
    checkOutput("fetch_lesen",   32'(SpeicherLesen), 32'h1);
    checkOutput("fetch_adresse", SpeicherAdresse,    32'h40);
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("fetch_puls",  32'(InstruktionGeladen), 32'h1);
    checkOutput("fetch_instr", Instruktion,             32'hDEADBEEF);
    checkOutput("fetch_ende",  32'(SpeicherLesen),      32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("fetch_einzel", 32'(InstruktionGeladen), 32'h0);

    // Ties after reset alternate, starting with the instruction port.
    pulseReset();
    applyStimulus(1, 32'h80, 1, 0, 32'h200, 0, 0, 0);
    applyStimulus(1, 32'h80, 1, 0, 32'h200, 0, 1, 32'h11111111);
    checkOutput("tie1_adresse", SpeicherAdresse, 32'h80);
    applyStimulus(1, 32'h80, 1, 0, 32'h200, 0, 0, 0);
    checkOutput("tie1_puls", 32'(InstruktionGeladen), 32'h1);
    checkOutput("tie1_wert", Instruktion, 32'h11111111);
    applyStimulus(1, 32'h80, 1, 0, 32'h200, 0, 0, 0);
    applyStimulus(1, 32'h80, 1, 0, 32'h200, 0, 1, 32'h22222222);
    checkOutput("tie2_adresse", SpeicherAdresse, 32'h200);
    applyStimulus(1, 32'h80, 1, 0, 32'h200, 0, 0, 0);
    checkOutput("tie2_puls", 32'(DatenGeladen), 32'h1);
    checkOutput("tie2_wert", DatenRein, 32'h22222222);
    applyStimulus(1, 32'h80, 1, 0, 32'h200, 0, 0, 0);
    applyStimulus(0, 32'h80, 0, 0, 32'h200, 0, 1, 32'h33333333);
    checkOutput("tie3_adresse", SpeicherAdresse, 32'h80);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("drop_puls", 32'(InstruktionGeladen), 32'h1);
    checkOutput("drop_wert", Instruktion, 32'h33333333);

    // Store with load also raised and memory ready immediately.
    applyStimulus(0, 0, 1, 1, 32'h100, 32'h12345678, 1, 0);
    applyStimulus(0, 0, 1, 1, 32'h100, 32'h12345678, 1, 0);
    checkOutput("store_strobe", 32'(SpeicherSchreiben), 32'h1);
    checkOutput("store_lesen",  32'(SpeicherLesen),     32'h0);
    checkOutput("store_addr",   SpeicherAdresse,        32'h100);
    checkOutput("store_daten",  SpeicherDatenRaus,      32'h12345678);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("store_puls",   32'(DatenGespeichert), 32'h1);
    checkOutput("store_keinLd", 32'(DatenGeladen),     32'h0);

    // Ready arriving in the last allowed cycle still completes normally.
    applyStimulus(0, 0, 1, 0, 32'h400, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 1, 0, 32'h400, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 32'h400, 0, 1, 32'hCAFEF00D);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("grenz_wert",   DatenRein,    32'hCAFEF00D);
    checkOutput("grenz_fehler", 32'(Fehler),  32'h0);

    // Load with no ready aborts after four access cycles.
    applyStimulus(0, 0, 1, 0, 32'h300, 0, 0, 0);
    repeat (4) applyStimulus(0, 0, 1, 0, 32'h300, 0, 0, 0);
    checkOutput("to_strobe4", 32'(SpeicherLesen), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("to_strobe5", 32'(SpeicherLesen), 32'h0);
    checkOutput("to_puls",    32'(DatenGeladen),  32'h1);
    checkOutput("to_wert",    DatenRein,          32'h0);
    checkOutput("to_fehler",  32'(Fehler),        32'h1);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("to_sticky",  32'(Fehler),        32'h1);

    // Reset in the middle of an access, then a clean fetch.
    applyStimulus(1, 32'h500, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h500, 0, 0, 0, 0, 0, 0);
    checkOutput("mr_vorher", 32'(SpeicherLesen), 32'h1);
    #1 Reset = 1'b1;
    #1;
    checkOutput("mr_lesen",  32'(SpeicherLesen), 32'h0);
    checkOutput("mr_fehler", 32'(Fehler),        32'h0);
    applyStimulus(1, 32'h500, 0, 0, 0, 0, 0, 0);
    Reset = 1'b0;
    applyStimulus(1, 32'h500, 0, 0, 0, 0, 0, 0);
    checkOutput("mr_keinPuls", 32'(InstruktionGeladen), 32'h0);
    applyStimulus(1, 32'h500, 0, 0, 0, 0, 1, 32'h0BADCAFE);
    checkOutput("mr_adresse", SpeicherAdresse, 32'h500);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("mr_puls", 32'(InstruktionGeladen), 32'h1);
    checkOutput("mr_wert", Instruktion, 32'h0BADCAFE);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
